i2c_slave_responder: RTL and testbench
======================================

// Module: i2c_slave_responder
// PURPOSE
// Synthesisable, parametrised I2C target (slave) for the I2C multi-bus verification environment.
// Oversamples SCL/SDA on the system clock, detects START, repeated START and STOP, and matches up to NUM_SLAVES addresses.
// Drives ACK/NACK and read bits open-drain. Streams write bytes out and requests read bytes through a valid/ready-style handshake.
// Holds SCL low (clock stretching) while waiting for read data.
// PARAMETERS
// I2C_ADDR_WIDTH  7   target address width in bits
// I2C_DATA_WIDTH  8   data byte width in bits
// NUM_SLAVES      2   number of address-table entries (1..8)
// SYNC_STAGES     2   synchroniser flops on scl_i/sda_i (>=2)
// STRETCH_EN      1   1: hold SCL low until rd_valid; 0: no stretch, send all-ones if data is late
// PORTS
// clk        in   1                        system clock
// rst_n      in   1                        asynchronous active-low reset
// scl_i      in   1                        SCL as seen on the bus
// sda_i      in   1                        SDA as seen on the bus
// scl_oe     out  1                        1 = pull SCL low (stretch)
// sda_oe     out  1                        1 = pull SDA low (ACK / read 0)
// slave_addr in   NUM_SLAVES*ADDR_W        address table; entry k = bits [k*W +: W]
// slave_en   in   NUM_SLAVES               per-entry enable
// sel        out  max(1,$clog2(NUM_SLAVES)) index of matched entry, valid while busy
// op         out  1                        0 = WRITE, 1 = READ; latched at the R/W bit
// wr_valid   out  1                        1-cycle pulse; wr_data valid
// wr_data    out  DATA_W                   received byte, MSB first
// rd_req     out  1                        level; a read byte is needed
// rd_valid   in   1                        rd_data accepted when rd_req && rd_valid
// rd_data    in   DATA_W                   byte to transmit, MSB first
// start_det  out  1                        pulse on START or repeated START
// stop_det   out  1                        pulse on STOP
// nack_rcvd  out  1                        pulse when master NACKs a read byte
// busy       out  1                        addressed transfer in progress
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, address/data shift registers 0.
// - Sync: scl/sda pass through SYNC_STAGES flops. Edges are detected on the synchronised values. All event latencies below are counted from the synchronised edge.
// - START: sda falls while scl high. STOP: sda rises while scl high. Both pulse 1 cycle after the edge.
// - START/STOP in any state override everything. START -> ADDR with bit count 0. STOP -> IDLE. Either releases scl_oe/sda_oe in the same cycle.
// - Sampling: bits are sampled on scl rising. Outputs change 1 cycle after scl falling; setup margin = low period.
// - FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_WAIT, RD_DATA, RD_ACK, IGNORE.
// - ADDR: shift ADDR_W bits, then the R/W bit into op.
//   - Match = lowest index k with slave_en[k] && entry k == shifted address.
//   - Match -> ADDR_ACK, sel=k, busy=1. No match -> IGNORE; SDA stays released, NACK, no outputs.
// - ADDR_ACK: sda_oe=1 for one SCL period.
//   - On the following scl falling: WRITE -> WR_DATA; READ -> RD_WAIT.
// - WR_DATA: shift DATA_W bits.
//   - wr_valid pulses with wr_data 1 cycle after the 8th rising edge. Then -> WR_ACK: sda_oe=1 for the ACK period, then WR_DATA.
// - RD_WAIT: rd_req=1.
//   - If rd_valid is already high, load the byte immediately.
//   - Else with STRETCH_EN=1: scl_oe=1 while scl is low until rd_valid, then release scl 1 cycle after the load.
//   - STRETCH_EN=0 and no rd_valid by the first scl rising: transmit all-ones.
//   - On load, rd_req drops the next cycle -> RD_DATA.
// - RD_DATA: drive MSB first. sda_oe = ~bit; released after the last bit's scl falling edge.
// - RD_ACK: sample master ACK on scl rising.
//   - 0 (ACK) -> RD_WAIT.
//   - 1 (NACK) -> nack_rcvd pulse -> IGNORE until STOP or START.
// - Repeated START keeps busy deasserted only until the new address phase resolves. op/sel update at the new address.
// - Simultaneous rd_valid and START: START wins and the byte is discarded.
// - Mid-transfer async reset: scl_oe/sda_oe release immediately, so the bus is never held low by reset.
// - Never drive sda_oe while scl is high except to hold a bit already driven during the low phase.
// TESTING
// - Reset while sda_oe=1 mid-ACK -> sda_oe and scl_oe drop to 0 asynchronously; FSM reads IDLE after release.
// - slave_addr={7'h22,7'h10}, en=2'b11; write to 0x22 with bytes 0xA5,0x3C, STOP -> ACK on address and each byte; wr_valid x2 with 0xA5,0x3C; sel=1; stop_det pulse.
// - Write to 0x55 (unmatched) -> SDA never pulled; no wr_valid; busy stays 0.
// - Read from 0x10, STRETCH_EN=1, rd_valid delayed 50 cycles, data 0x81 then 0x7E, master NACKs the 2nd byte -> scl_oe held 50 cycles; bus bits 10000001, 01111110; nack_rcvd=1.
// - Write 0x10 byte 0xFF, repeated START, read 0x22 -> start_det x2; op 0 then 1; sel 0 then 1; read proceeds without STOP.
// - STRETCH_EN=0, read with rd_valid never asserted -> byte 0xFF on bus; no scl_oe activity.

Source files
------------

// File: rtl/i2c_slave_responder.sv
// I2C target with an oversampled SCL/SDA front end, a multi-entry address table and
// byte-wide write/read handshakes; optionally stretches SCL while read data is pending.
module i2c_slave_responder #(
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int NUM_SLAVES     = 2,
    parameter int SYNC_STAGES    = 2,
    parameter bit STRETCH_EN     = 1'b1,
    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 scl_i,
    input  logic                                 sda_i,
    output logic                                 scl_oe,
    output logic                                 sda_oe,
    input  logic [NUM_SLAVES*I2C_ADDR_WIDTH-1:0] slave_addr,
    input  logic [NUM_SLAVES-1:0]                slave_en,
    output logic [SEL_W-1:0]                     sel,
    output logic                                 op,
    output logic                                 wr_valid,
    output logic [I2C_DATA_WIDTH-1:0]            wr_data,
    output logic                                 rd_req,
    input  logic                                 rd_valid,
    input  logic [I2C_DATA_WIDTH-1:0]            rd_data,
    output logic                                 start_det,
    output logic                                 stop_det,
    output logic                                 nack_rcvd,
    output logic                                 busy
);
    localparam int AW    = I2C_ADDR_WIDTH;
    localparam int DW    = I2C_DATA_WIDTH;
    localparam int SR_W  = (AW > DW) ? AW : DW;
    localparam int CNT_W = $clog2(SR_W + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(AW);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DW - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK,
        S_RD_WAIT, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic [SR_W-1:0]        sr;
    logic [CNT_W-1:0]       cnt;
    logic                   phase;
    logic                   hit;
    logic [SEL_W-1:0]       hit_idx;

    wire scl_s      = scl_sync[SYNC_STAGES-1];
    wire sda_s      = sda_sync[SYNC_STAGES-1];
    wire scl_rise   = scl_s & ~scl_d;
    wire scl_fall   = ~scl_s & scl_d;
    wire start_cond = scl_s & scl_d & sda_d & ~sda_s;
    wire stop_cond  = scl_s & scl_d & ~sda_d & sda_s;

    // Scan from the top so the lowest matching enabled entry wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (slave_en[k] && slave_addr[k*AW +: AW] == sr[AW-1:0]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            state     <= S_IDLE;
            sr        <= '0;
            cnt       <= '0;
            phase     <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            sel       <= '0;
            op        <= 1'b0;
            wr_valid  <= 1'b0;
            wr_data   <= '0;
            rd_req    <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            nack_rcvd <= 1'b0;
            busy      <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d     <= scl_s;
            sda_d     <= sda_s;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            wr_valid  <= 1'b0;
            nack_rcvd <= 1'b0;
            if (start_cond) begin
                start_det <= 1'b1;
                state     <= S_ADDR;
                cnt       <= '0;
                busy      <= 1'b0;
                scl_oe    <= 1'b0;
                sda_oe    <= 1'b0;
                rd_req    <= 1'b0;
            end else if (stop_cond) begin
                stop_det <= 1'b1;
                state    <= S_IDLE;
                busy     <= 1'b0;
                scl_oe   <= 1'b0;
                sda_oe   <= 1'b0;
                rd_req   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_IGNORE: ;
                    S_ADDR: if (scl_rise) begin
                        if (cnt == ADDR_LAST) begin
                            if (hit) begin
                                op    <= sda_s;
                                sel   <= hit_idx;
                                busy  <= 1'b1;
                                phase <= 1'b0;
                                state <= S_ADDR_ACK;
                            end else begin
                                state <= S_IGNORE;
                            end
                        end else begin
                            sr  <= {sr[SR_W-2:0], sda_s};
                            cnt <= cnt + 1'b1;
                        end
                    end
                    // phase 0: waiting for the fall that opens the ACK slot; 1: ACK driven.
                    S_ADDR_ACK, S_WR_ACK: if (scl_fall) begin
                        if (!phase) begin
                            sda_oe <= 1'b1;
                            phase  <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            state  <= (state == S_ADDR_ACK && op) ? S_RD_WAIT : S_WR_DATA;
                        end
                    end
                    S_WR_DATA: if (scl_rise) begin
                        sr <= {sr[SR_W-2:0], sda_s};
                        if (cnt == DATA_LAST) begin
                            wr_data  <= {sr[DW-2:0], sda_s};
                            wr_valid <= 1'b1;
                            phase    <= 1'b0;
                            state    <= S_WR_ACK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    // sr holds the bits still to send, MSB-aligned; the MSB goes out on load.
                    S_RD_WAIT: begin
                        if (rd_req && rd_valid && !scl_s) begin
                            sr     <= SR_W'({rd_data[DW-2:0], 1'b1});
                            sda_oe <= ~rd_data[DW-1];
                            rd_req <= 1'b0;
                            scl_oe <= 1'b0;
                            cnt    <= '0;
                            state  <= S_RD_DATA;
                        end else if (!STRETCH_EN && scl_rise) begin
                            sr     <= '1;
                            rd_req <= 1'b0;
                            cnt    <= '0;
                            state  <= S_RD_DATA;
                        end else begin
                            rd_req <= 1'b1;
                            scl_oe <= STRETCH_EN && !scl_s;
                        end
                    end
                    S_RD_DATA: if (scl_fall) begin
                        if (cnt == DATA_LAST) begin
                            sda_oe <= 1'b0;
                            phase  <= 1'b0;
                            state  <= S_RD_ACK;
                        end else begin
                            sda_oe <= ~sr[DW-1];
                            sr     <= {sr[SR_W-2:0], 1'b1};
                            cnt    <= cnt + 1'b1;
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                nack_rcvd <= 1'b1;
                                state     <= S_IGNORE;
                            end else begin
                                phase <= 1'b1;
                            end
                        end else if (scl_fall && phase) begin
                            cnt   <= '0;
                            state <= S_RD_WAIT;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bus-level bench: a bit-banged master on a wired-AND bus shared by a stretching and
// a non-stretching target; written bytes and read bytes are scoreboarded through queues.
module tb_i2c_slave_responder;
    localparam int H = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic scl_m = 1'b1, sda_m = 1'b1;
    logic scl_oe0, sda_oe0, scl_oe1, sda_oe1;
    logic scl_bus, sda_bus;
    assign scl_bus = scl_m & ~scl_oe0 & ~scl_oe1;
    assign sda_bus = sda_m & ~sda_oe0 & ~sda_oe1;

    logic [13:0] addr0 = {7'h22, 7'h10};
    logic [13:0] addr1 = {7'h33, 7'h44};
    logic [1:0]  en0 = 2'b11, en1 = 2'b01;
    logic [0:0]  sel0, sel1;
    logic        op0, op1, wr_valid0, wr_valid1, rd_req0, rd_req1;
    logic [7:0]  wr_data0, wr_data1;
    logic        rd_valid0, rd_valid1;
    logic [7:0]  rd_data0, rd_data1;
    logic        start_det0, start_det1, stop_det0, stop_det1;
    logic        nack0, nack1, busy0, busy1;

    i2c_slave_responder #(.STRETCH_EN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_oe(scl_oe0), .sda_oe(sda_oe0), .slave_addr(addr0), .slave_en(en0),
        .sel(sel0), .op(op0), .wr_valid(wr_valid0), .wr_data(wr_data0),
        .rd_req(rd_req0), .rd_valid(rd_valid0), .rd_data(rd_data0),
        .start_det(start_det0), .stop_det(stop_det0), .nack_rcvd(nack0), .busy(busy0));

    i2c_slave_responder #(.STRETCH_EN(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_oe(scl_oe1), .sda_oe(sda_oe1), .slave_addr(addr1), .slave_en(en1),
        .sel(sel1), .op(op1), .wr_valid(wr_valid1), .wr_data(wr_data1),
        .rd_req(rd_req1), .rd_valid(rd_valid1), .rd_data(rd_data1),
        .start_det(start_det1), .stop_det(stop_det1), .nack_rcvd(nack1), .busy(busy1));

    int tests_run = 0, tests_failed = 0;
    int n_start0 = 0, n_stop0 = 0, n_wr0 = 0, n_nack0 = 0, n_nack1 = 0;
    int n_sclo0 = 0, n_sdao0 = 0, n_busy0 = 0, n_sclo1 = 0, n_wr1 = 0;
    int rd_delay = 0;
    logic [7:0] exp_wr[$], exp_rd[$], rd_src[$];
    logic [7:0] e_wr;

    // Event counters plus the write-side scoreboard check.
    initial forever begin
        @(negedge clk);
        if (start_det0) n_start0++;
        if (stop_det0)  n_stop0++;
        if (nack0)      n_nack0++;
        if (nack1)      n_nack1++;
        if (scl_oe0)    n_sclo0++;
        if (sda_oe0)    n_sdao0++;
        if (busy0)      n_busy0++;
        if (scl_oe1)    n_sclo1++;
        if (wr_valid1)  n_wr1++;
        if (wr_valid0) begin
            n_wr0++;
            tests_run++;
            if (exp_wr.size() == 0) begin
                tests_failed++;
                $display("FAIL wr_data: got unexpected byte %02h, required none", wr_data0);
            end else begin
                e_wr = exp_wr.pop_front();
                if (wr_data0 !== e_wr) begin
                    tests_failed++;
                    $display("FAIL wr_data: got %02h, required %02h", wr_data0, e_wr);
                end
            end
        end
    end

    // Read-data source for dut0; every byte presented becomes an expected bus byte.
    initial begin
        rd_valid0 = 1'b0;
        rd_data0  = 8'h00;
        rd_valid1 = 1'b0;
        rd_data1  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (rd_req0 && !rd_valid0) begin
                repeat (rd_delay) begin @(posedge clk); #1; end
                rd_data0 = 8'h00;
                if (rd_src.size() != 0) rd_data0 = rd_src.pop_front();
                exp_rd.push_back(rd_data0);
                rd_valid0 = 1'b1;
                @(posedge clk); #1;
                rd_valid0 = 1'b0;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clock_bit(input logic b, output logic r);
        int n;
        tick(2);
        sda_m = b;
        tick(H - 2);
        scl_m = 1'b1;
        n = 0;
        while (!scl_bus && n < 5000) begin tick(1); n++; end
        if (n >= 5000) begin
            tests_run++; tests_failed++;
            $display("FAIL scl_release: scl low for %0d cycles, required release", n);
        end
        tick(H / 2);
        r = sda_bus;
        tick(H / 2);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        tick(2);
        sda_m = 1'b1; tick(H);
        scl_m = 1'b1; tick(H);
        sda_m = 1'b0; tick(H);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(2);
        sda_m = 1'b0; tick(H);
        scl_m = 1'b1; tick(H);
        sda_m = 1'b1; tick(H);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin clock_bit(1'b1, r); d[i] = r; end
        clock_bit(nack, r);
    endtask

    task automatic test_reset();
        logic r;
        rst_n = 1'b0;
        tick(3);
        tests_run++;
        if ({scl_oe0, sda_oe0, busy0, wr_valid0, rd_req0, start_det0, stop_det0, nack0,
             op0, sel0, wr_data0, scl_oe1, sda_oe1} !== 21'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, required 0",
                {scl_oe0, sda_oe0, busy0, wr_valid0, rd_req0, start_det0, stop_det0, nack0,
                 op0, sel0, wr_data0, scl_oe1, sda_oe1});
        end
        rst_n = 1'b1;
        tick(3);
        i2c_start();
        for (int i = 7; i >= 0; i--) clock_bit(i == 0 ? 1'b0 : 1'(7'h22 >> (i - 1)), r);
        tick(6);
        tests_run++;
        if (sda_oe0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL ack_before_reset: sda_oe got %b, required 1", sda_oe0);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({scl_oe0, sda_oe0} !== 2'b00) begin
            tests_failed++;
            $display("FAIL async_reset_release: scl_oe,sda_oe got %b, required 00", {scl_oe0, sda_oe0});
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        tests_run++;
        if (int'(dut0.state) !== 0 || busy0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL state_after_reset: state %0d busy %b, required 0 0", int'(dut0.state), busy0);
        end
        i2c_stop();
    endtask

    task automatic test_write();
        logic ack;
        logic [7:0] bytes [2];
        int wr_s, stop_s;
        bytes[0] = 8'hA5; bytes[1] = 8'h3C;
        wr_s = n_wr0; stop_s = n_stop0;
        i2c_start();
        write_byte({7'h22, 1'b0}, ack);
        tests_run++;
        if (ack !== 1'b0 || sel0 !== 1'b1 || op0 !== 1'b0 || busy0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_addr: ack %b sel %b op %b busy %b, required 0 1 0 1", ack, sel0, op0, busy0);
        end
        for (int i = 0; i < 2; i++) begin
            exp_wr.push_back(bytes[i]);
            write_byte(bytes[i], ack);
            tests_run++;
            if (ack !== 1'b0) begin
                tests_failed++;
                $display("FAIL write_data_ack: byte %0d ack %b, required 0", i, ack);
            end
        end
        i2c_stop();
        tick(5);
        tests_run++;
        if (n_wr0 - wr_s !== 2 || n_stop0 - stop_s !== 1 || busy0 !== 1'b0 || exp_wr.size() !== 0) begin
            tests_failed++;
            $display("FAIL write_summary: wr %0d stop %0d busy %b pending %0d, required 2 1 0 0",
                n_wr0 - wr_s, n_stop0 - stop_s, busy0, exp_wr.size());
        end
    endtask

    task automatic test_unmatched();
        logic ack;
        int sda_s, busy_s, wr_s;
        sda_s = n_sdao0; busy_s = n_busy0; wr_s = n_wr0 + n_wr1;
        i2c_start();
        write_byte({7'h55, 1'b0}, ack);
        tests_run++;
        if (ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL unmatched_addr_ack: got %b, required 1 (NACK)", ack);
        end
        write_byte(8'h12, ack);
        tests_run++;
        if (ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL unmatched_data_ack: got %b, required 1 (NACK)", ack);
        end
        i2c_stop();
        tests_run++;
        if (n_sdao0 != sda_s || n_busy0 != busy_s || n_wr0 + n_wr1 != wr_s) begin
            tests_failed++;
            $display("FAIL unmatched_quiet: sda_oe %0d busy %0d wr %0d cycles, required 0 0 0",
                n_sdao0 - sda_s, n_busy0 - busy_s, n_wr0 + n_wr1 - wr_s);
        end
    endtask

    task automatic test_read_stretch();
        logic ack;
        logic [7:0] d, e;
        int scl_s0, nack_s;
        rd_delay = 50;
        rd_src.push_back(8'h81);
        rd_src.push_back(8'h7E);
        scl_s0 = n_sclo0; nack_s = n_nack0;
        i2c_start();
        write_byte({7'h10, 1'b1}, ack);
        tests_run++;
        if (ack !== 1'b0 || op0 !== 1'b1 || sel0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_addr: ack %b op %b sel %b, required 0 1 0", ack, op0, sel0);
        end
        for (int i = 0; i < 2; i++) begin
            read_byte(i == 1, d);
            tests_run++;
            if (exp_rd.size() == 0) begin
                tests_failed++;
                $display("FAIL read_byte%0d: got %02h, required a presented byte", i, d);
            end else begin
                e = exp_rd.pop_front();
                if (d !== e) begin
                    tests_failed++;
                    $display("FAIL read_byte%0d: got %02h, required %02h", i, d, e);
                end
            end
            if (i == 0) begin
                tests_run++;
                if (n_sclo0 - scl_s0 < 50 || n_sclo0 - scl_s0 > 52) begin
                    tests_failed++;
                    $display("FAIL stretch_len: scl_oe %0d cycles, required 50..52", n_sclo0 - scl_s0);
                end
            end
        end
        tests_run++;
        if (n_nack0 - nack_s !== 1) begin
            tests_failed++;
            $display("FAIL nack_rcvd: got %0d pulses, required 1", n_nack0 - nack_s);
        end
        i2c_stop();
        rd_delay = 0;
    endtask

    task automatic test_back_to_back();
        logic ack;
        logic [7:0] d, e;
        int start_s, stop_s;
        rd_src.push_back(8'h5A);
        start_s = n_start0; stop_s = n_stop0;
        i2c_start();
        write_byte({7'h10, 1'b0}, ack);
        tests_run++;
        if (ack !== 1'b0 || op0 !== 1'b0 || sel0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL rs_first_addr: ack %b op %b sel %b, required 0 0 0", ack, op0, sel0);
        end
        exp_wr.push_back(8'hFF);
        write_byte(8'hFF, ack);
        i2c_start();
        tests_run++;
        if (busy0 !== 1'b0 || ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL rs_restart: busy %b data_ack %b, required 0 0", busy0, ack);
        end
        write_byte({7'h22, 1'b1}, ack);
        tests_run++;
        if (ack !== 1'b0 || op0 !== 1'b1 || sel0 !== 1'b1 || busy0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL rs_second_addr: ack %b op %b sel %b busy %b, required 0 1 1 1", ack, op0, sel0, busy0);
        end
        read_byte(1'b1, d);
        tests_run++;
        e = (exp_rd.size() != 0) ? exp_rd.pop_front() : 8'hxx;
        if (d !== e) begin
            tests_failed++;
            $display("FAIL rs_read: got %02h, required %02h", d, e);
        end
        tests_run++;
        if (n_start0 - start_s !== 2 || n_stop0 !== stop_s) begin
            tests_failed++;
            $display("FAIL rs_events: start %0d stop %0d, required 2 0", n_start0 - start_s, n_stop0 - stop_s);
        end
        i2c_stop();
    endtask

    task automatic test_no_stretch();
        logic ack;
        logic [7:0] d;
        int scl_s1, nack_s;
        scl_s1 = n_sclo1; nack_s = n_nack1;
        i2c_start();
        write_byte({7'h44, 1'b1}, ack);
        tests_run++;
        if (ack !== 1'b0 || op1 !== 1'b1 || busy1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL nostretch_addr: ack %b op %b busy %b, required 0 1 1", ack, op1, busy1);
        end
        read_byte(1'b1, d);
        tests_run++;
        if (d !== 8'hFF) begin
            tests_failed++;
            $display("FAIL nostretch_data: got %02h, required ff", d);
        end
        tests_run++;
        if (n_sclo1 != scl_s1 || n_nack1 - nack_s !== 1) begin
            tests_failed++;
            $display("FAIL nostretch_bus: scl_oe %0d cycles nack %0d, required 0 1", n_sclo1 - scl_s1, n_nack1 - nack_s);
        end
        i2c_stop();
    endtask

    initial begin
        test_reset();
        test_write();
        test_unmatched();
        test_read_stretch();
        test_back_to_back();
        test_no_stretch();
        tick(10);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
